// File: rtl/counter_modulo_ctrl.sv
// Up/down modulo counter with run-time limit, synchronous load and
// wrap / saturate / one-shot terminal-count behaviour.
module counter_modulo_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done,
    output logic             at_max,
    output logic             at_min
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_e;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'b00,
        MODE_SAT     = 2'b01,
        MODE_ONESHOT = 2'b10,
        MODE_RSVD    = 2'b11
    } mode_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, tc_d;
    logic             done_q, done_d;

    mode_e mode_sel;
    logic  is_wrap;
    logic  is_oneshot;
    logic  up_terminal;
    logic  down_terminal;

    assign mode_sel   = mode_e'(mode);
    assign is_wrap    = (mode_sel == MODE_WRAP) || (mode_sel == MODE_RSVD);
    assign is_oneshot = (mode_sel == MODE_ONESHOT);

    // A zero limit makes every step terminal, including a down step from a
    // count left above the freshly lowered limit.
    assign up_terminal   = (count_q >= limit);
    assign down_terminal = (count_q == '0) || (limit == '0);

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        state_d = state_q;
        count_d = count_q;
        tc_d    = 1'b0;
        done_d  = done_q;

        if (load) begin
            count_d = (load_val > limit) ? limit : load_val;
            state_d = ST_RUN;
            done_d  = 1'b0;
        end else if (en && (state_q == ST_RUN)) begin
            if (up) begin
                if (up_terminal) begin
                    tc_d    = 1'b1;
                    count_d = is_wrap ? '0 : limit;
                end else begin
                    count_d = count_q + WIDTH'(1);
                end
            end else begin
                if (down_terminal) begin
                    tc_d    = 1'b1;
                    count_d = is_wrap ? limit : '0;
                end else if (count_q > limit) begin
                    count_d = limit;
                end else begin
                    count_d = count_q - WIDTH'(1);
                end
            end

            if (tc_d && is_oneshot) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops
    // sample the same pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            count_q <= '0;
            tc_q    <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            tc_q    <= tc_d;
            done_q  <= done_d;
        end
    end

    assign count  = count_q;
    assign tc     = tc_q;
    assign done   = done_q;
    assign at_max = (count_q >= limit);
    assign at_min = (count_q == '0);

endmodule

// File: tb/tb_counter_modulo_ctrl.sv
// Scoreboard bench for counter_modulo_ctrl: directed scenarios followed by
// randomized traffic, all checked against a behavioural reference model.
module tb_counter_modulo_ctrl;

    localparam logic [1:0] WRAP    = 2'd0;
    localparam logic [1:0] SAT     = 2'd1;
    localparam logic [1:0] ONESHOT = 2'd2;
    localparam logic [1:0] RSVD    = 2'd3;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic [1:0] mode;
    logic [7:0] limit;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] count;
    logic       tc;
    logic       done;
    logic       at_max;
    logic       at_min;

    counter_modulo_ctrl #(.WIDTH(8)) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .limit    (limit),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .tc       (tc),
        .done     (done),
        .at_max   (at_max),
        .at_min   (at_min)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int   cyc;
        logic [7:0] count;
        logic tc;
        logic done;
        logic at_max;
        logic at_min;
    } exp_t;

    exp_t sb_q[$];

    int n_checks = 0;
    int n_fails  = 0;
    int n_cycles = 0;

    // Reference model state
    int unsigned m_count = 0;
    bit          m_tc    = 0;
    bit          m_done  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_count = 0;
        m_tc    = 0;
        m_done  = 0;
    endtask

    // One clock of stimulus: drive inputs away from the active edge, advance
    // the model and queue the response expected after the next posedge.
    task automatic cyc(input bit ld, input logic [7:0] lv, input bit e, input bit u,
                       input logic [1:0] m, input logic [7:0] lim);
        exp_t x;
        int   c;
        int   l;
        bit   wrap;
        @(negedge clk);
        load = ld; load_val = lv; en = e; up = u; mode = m; limit = lim;
        c    = int'(m_count);
        l    = int'(lim);
        wrap = (m == WRAP) || (m == RSVD);
        if (ld) begin
            m_count = (int'(lv) > l) ? l : int'(lv);
            m_tc    = 0;
            m_done  = 0;
        end else if (m_done || !e) begin
            m_tc = 0;
        end else if (u) begin
            if (c < l) begin
                m_count = c + 1;
                m_tc    = 0;
            end else begin
                m_tc    = 1;
                m_count = wrap ? 0 : l;
                if (m == ONESHOT) m_done = 1;
            end
        end else begin
            if (c == 0 || l == 0) begin
                m_tc    = 1;
                m_count = wrap ? l : 0;
                if (m == ONESHOT) m_done = 1;
            end else if (c > l) begin
                m_count = l;
                m_tc    = 0;
            end else begin
                m_count = c - 1;
                m_tc    = 0;
            end
        end
        n_cycles++;
        x.cyc    = n_cycles;
        x.count  = m_count[7:0];
        x.tc     = m_tc;
        x.done   = m_done;
        x.at_max = (int'(m_count) >= l);
        x.at_min = (m_count == 0);
        sb_q.push_back(x);
    endtask

    task automatic settle();
        @(posedge clk);
        #2;
    endtask

    // Monitor: every edge that has a queued expectation is compared.
    initial begin
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                x = sb_q.pop_front();
                check($sformatf("count@%0d", x.cyc),  count,  x.count);
                check($sformatf("tc@%0d", x.cyc),     tc,     x.tc);
                check($sformatf("done@%0d", x.cyc),   done,   x.done);
                check($sformatf("at_max@%0d", x.cyc), at_max, x.at_max);
                check($sformatf("at_min@%0d", x.cyc), at_min, x.at_min);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        n_fails++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] r_lim;
        logic [1:0] r_mode;
        bit         r_up;

        rst = 1'b0; en = 1'b0; up = 1'b0; mode = WRAP;
        limit = 8'd9; load = 1'b0; load_val = 8'd0;
        #12;
        check("reset_count",  count,  0);
        check("reset_tc",     tc,     0);
        check("reset_done",   done,   0);
        check("reset_at_min", at_min, 1);
        @(negedge clk);
        rst = 1'b1;
        model_reset();

        // 1: WRAP up, limit 9
        for (int i = 0; i < 11; i++) cyc(0, 0, 1, 1, WRAP, 8'd9);
        settle();
        check("t1_count", count, 1);
        check("t1_tc",    tc,    0);

        // 2: WRAP down from 0
        cyc(1, 8'd0, 0, 0, WRAP, 8'd9);
        cyc(0, 0, 1, 0, WRAP, 8'd9);
        settle();
        check("t2_count_a", count, 9);
        check("t2_tc_a",    tc,    1);
        cyc(0, 0, 1, 0, WRAP, 8'd9);
        settle();
        check("t2_count_b", count, 8);
        check("t2_tc_b",    tc,    0);

        // 3: SAT up, limit 5
        cyc(1, 8'd4, 0, 1, SAT, 8'd5);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 1, SAT, 8'd5);
        settle();
        check("t3_count",  count,  5);
        check("t3_tc",     tc,     1);
        check("t3_at_max", at_max, 1);

        // 4: ONESHOT down, limit 9
        cyc(1, 8'd3, 0, 0, ONESHOT, 8'd9);
        for (int i = 0; i < 4; i++) cyc(0, 0, 1, 0, ONESHOT, 8'd9);
        settle();
        check("t4_done_set", done, 1);
        check("t4_count_0",  count, 0);
        cyc(0, 0, 1, 1, ONESHOT, 8'd9);
        cyc(0, 0, 1, 1, WRAP, 8'd9);
        settle();
        check("t4_done_hold", done,  1);
        check("t4_count_hold", count, 0);
        check("t4_tc_hold",   tc,    0);
        cyc(1, 8'd7, 1, 1, WRAP, 8'd9);
        settle();
        check("t4_reload_count", count, 7);
        check("t4_reload_done",  done,  0);

        // 5: load clamping, load over enable, run-time limit lowering
        cyc(1, 8'd200, 0, 1, WRAP, 8'd9);
        settle();
        check("t5_clamp", count, 9);
        cyc(1, 8'd2, 1, 1, WRAP, 8'd9);
        settle();
        check("t5_load_prio", count, 2);
        cyc(1, 8'd9, 0, 0, WRAP, 8'd9);
        cyc(0, 0, 1, 0, WRAP, 8'd4);
        settle();
        check("t5_lowered", count, 4);
        check("t5_lowered_tc", tc, 0);

        // limit 0: every step is terminal
        cyc(0, 0, 1, 0, SAT, 8'd0);
        cyc(0, 0, 1, 1, WRAP, 8'd0);
        settle();
        check("lim0_count", count, 0);
        check("lim0_tc",    tc,    1);

        // 6: asynchronous reset mid-operation
        cyc(1, 8'd5, 0, 1, ONESHOT, 8'd6);
        cyc(0, 0, 1, 1, ONESHOT, 8'd6);
        cyc(0, 0, 1, 1, ONESHOT, 8'd6);
        settle();
        check("t6_pre_count", count, 6);
        check("t6_pre_done",  done,  1);
        #3;
        en = 1'b0; load = 1'b0;
        rst = 1'b0;
        #1;
        check("t6_rst_count", count, 0);
        check("t6_rst_done",  done,  0);
        check("t6_rst_tc",    tc,    0);
        model_reset();
        @(negedge clk);
        rst = 1'b1;
        cyc(0, 0, 1, 1, WRAP, 8'd9);
        cyc(0, 0, 1, 1, WRAP, 8'd9);
        settle();
        check("t6_restart", count, 2);

        // Randomized traffic
        r_lim  = 8'd12;
        r_mode = WRAP;
        r_up   = 1'b1;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 49) == 0) begin
                case ($urandom_range(0, 3))
                    0:       r_lim = 8'd0;
                    1:       r_lim = 8'd255;
                    2:       r_lim = 8'($urandom_range(0, 255));
                    default: r_lim = 8'($urandom_range(1, 15));
                endcase
            end
            if ($urandom_range(0, 29) == 0) r_mode = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0)  r_up = ~r_up;
            cyc(($urandom_range(0, 11) == 0),
                ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 20)) : 8'($urandom_range(0, 255)),
                ($urandom_range(0, 3) != 0), r_up, r_mode, r_lim);
        end

        for (int i = 0; i < 10 && sb_q.size() > 0; i++) @(posedge clk);
        #2;
        check("scoreboard_drained", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
